pixel_sensor_ctrl: RTL and testbench
====================================

# pixel_sensor_ctrl

Frame sequencer for the pixel array, parametrised in row count, ADC counter width and phase durations. It drives the global erase/expose/convert strobes and the digital ramp counter shared by all pixel rows. It then reads the rows out one at a time over a valid/ready handshake. It supports single-shot and continuous frame modes and sits between the top-level readout logic and the instantiated pixel rows.

## Interface
- N_ROWS, 4, number of pixel rows read out per frame (≥1)
- CNT_WIDTH, 8, width of the digital ramp counter; convert phase lasts 2^CNT_WIDTH cycles
- DUR_WIDTH, 8, width of the runtime erase/expose duration inputs

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low; one clock, synchronous reset active-low
- start  in  1  request one frame; sampled only in IDLE
- continuous  in  1  1 = start next frame automatically after readout; sampled at end of READ
- erase_cycles  in  DUR_WIDTH  erase phase length in cycles; latched on frame start
- expose_cycles  in  DUR_WIDTH  expose phase length in cycles; latched on frame start
- row_ready  in  1  downstream accepts current row
- erase  out  1  global pixel erase strobe
- expose  out  1  global exposure strobe
- convert  out  1  ramp active; pixels compare against adc_counter
- adc_counter  out  CNT_WIDTH  digital ramp value, broadcast to all rows
- read_row  out  N_ROWS  one-hot row select; all-zero outside READ
- row_idx  out  max(1,$clog2(N_ROWS))  binary index of selected row
- row_valid  out  1  selected row data on bus is valid
- busy  out  1  high in every state except IDLE
- frame_done  out  1  single-cycle pulse after last row accepted

## Operation
- States: IDLE, ERASE, EXPOSE, CONVERT, READ. All outputs are registered (Moore).
- IDLE: outputs all 0. If start=1 at an edge, latch erase_cycles and expose_cycles, then go to ERASE.
- ERASE: erase=1 for max(erase_cycles,1) cycles, then EXPOSE.
- EXPOSE: expose=1 for max(expose_cycles,1) cycles, then CONVERT.
- CONVERT: convert=1 for exactly 2^CNT_WIDTH cycles.
  - adc_counter is 0 in the first cycle and increments by 1 each cycle, reaching 2^CNT_WIDTH−1 in the last cycle. It does not wrap.
  - Leaving CONVERT returns adc_counter to 0; it is 0 in every other state.
  - Then go to READ with row 0.
- READ: read_row[r]=1, row_idx=r, row_valid=1.
  - Row r advances to r+1 on an edge with row_valid&row_ready.
  - With row_ready=0, row r is held indefinitely; no timeout.
  - On acceptance of row N_ROWS−1, pulse frame_done for 1 cycle.
  - Next state is ERASE if continuous=1 at that edge (new durations latched), else IDLE.
- start while busy=1 is ignored, with no queuing.
- Changes on erase_cycles/expose_cycles mid-frame have no effect.

## Timing
- reset=0 at an edge: next cycle state=IDLE. All outputs are 0: erase, expose, convert, adc_counter, read_row, row_idx, row_valid, busy and frame_done. Duration and row registers are cleared. This applies in any state, including mid-CONVERT or mid-READ.
- start=1 sampled at edge k: erase=1 and busy=1 from edge k. The erase phase occupies cycles k..k+E−1, and expose rises at edge k+E.
- Phase strobes are mutually exclusive; there is no gap cycle between phases.
- Frame length with row_ready tied 1: E + X + 2^CNT_WIDTH + N_ROWS cycles from start edge to frame_done.
  - frame_done is asserted in the first IDLE/ERASE cycle after the last handshake.
  - busy falls in the same cycle as frame_done when returning to IDLE.
- In continuous mode, erase rises in the same cycle as frame_done and busy stays 1.
- Single-row case (N_ROWS=1): READ lasts until the one handshake; row_idx constant 0.

## Test plan
- Single frame, N_ROWS=4, CNT_WIDTH=8, E=5, X=255, row_ready=1:
  - erase high 5 cycles, expose 255, convert 256 with adc_counter 0→255.
  - read_row 0001,0010,0100,1000 one cycle each.
  - frame_done pulse at start+520; busy low after.
- Backpressure: row_ready=0 for 3 cycles while row_idx=1 → read_row holds 0010 and row_valid stays 1 for 4 cycles; frame_done is delayed by 3 cycles.
- Zero durations: erase_cycles=0, expose_cycles=0 → erase and expose each 1 cycle.
- Continuous mode: continuous=1, two frames back-to-back.
  - erase re-asserts in the frame_done cycle and busy never drops.
  - New erase_cycles=2 applied on frame 2 only.
- Reset mid-CONVERT at adc_counter=100 → next cycle all outputs 0 and state IDLE; a subsequent start runs a full clean frame.
- start pulsed during EXPOSE → ignored; only one frame_done produced.

Source files
------------

// File: rtl/pixel_sensor_ctrl.sv
// Frame sequencer: erase -> expose -> convert (shared ADC ramp) -> row-by-row readout.
// Latency: all outputs registered; a frame with row_ready=1 takes E+X+2^CNT_WIDTH+N_ROWS cycles to frame_done.
// Backpressure: readout holds the current row (row_valid=1) until row_ready; no timeout.
//
// Ports:
//   clk, reset (sync, active-low)      - clock and reset
//   start, continuous                  - frame request / auto-restart after readout
//   erase_cycles, expose_cycles        - phase lengths, latched at frame start (0 behaves as 1)
//   row_ready                          - downstream accepts the selected row
//   erase, expose, convert             - mutually exclusive global phase strobes
//   adc_counter                        - ramp value during convert, 0 elsewhere
//   read_row, row_idx, row_valid       - one-hot / binary row select and its valid
//   busy, frame_done                   - not-idle flag, one-cycle end-of-frame pulse
module pixel_sensor_ctrl #(
    parameter  int N_ROWS    = 4,
    parameter  int CNT_WIDTH = 8,
    parameter  int DUR_WIDTH = 8,
    localparam int ROW_W     = (N_ROWS > 1) ? $clog2(N_ROWS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 continuous,
    input  logic [DUR_WIDTH-1:0] erase_cycles,
    input  logic [DUR_WIDTH-1:0] expose_cycles,
    input  logic                 row_ready,
    output logic                 erase,
    output logic                 expose,
    output logic                 convert,
    output logic [CNT_WIDTH-1:0] adc_counter,
    output logic [N_ROWS-1:0]    read_row,
    output logic [ROW_W-1:0]     row_idx,
    output logic                 row_valid,
    output logic                 busy,
    output logic                 frame_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_EXPOSE,
        S_CONVERT,
        S_READ
    } state_t;

    state_t               state_q, state_d;
    logic [DUR_WIDTH-1:0] cnt_q, cnt_d;
    logic [DUR_WIDTH-1:0] erase_len_q, erase_len_d;
    logic [DUR_WIDTH-1:0] expose_len_q, expose_len_d;
    logic [CNT_WIDTH-1:0] adc_q, adc_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic                 erase_q, erase_d;
    logic                 expose_q, expose_d;
    logic                 convert_q, convert_d;
    logic [N_ROWS-1:0]    read_row_q, read_row_d;
    logic                 row_valid_q, row_valid_d;
    logic                 busy_q, busy_d;
    logic                 frame_done_q, frame_done_d;

    // A programmed length of 0 is treated as 1 cycle, so the phase ends on cnt_q==0.
    logic erase_last, expose_last, ramp_last, row_last, row_accept;

    always_comb begin
        erase_last  = (erase_len_q  <= DUR_WIDTH'(1)) || (cnt_q == erase_len_q  - DUR_WIDTH'(1));
        expose_last = (expose_len_q <= DUR_WIDTH'(1)) || (cnt_q == expose_len_q - DUR_WIDTH'(1));
        ramp_last   = (adc_q == {CNT_WIDTH{1'b1}});
        row_last    = (row_q == ROW_W'(N_ROWS - 1));
        row_accept  = row_valid_q && row_ready;
    end

    // Next-state logic; outputs are then registered from state_d so they align with the state.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        erase_len_d  = erase_len_q;
        expose_len_d = expose_len_q;
        adc_d        = '0;
        row_d        = '0;
        frame_done_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    erase_len_d  = erase_cycles;
                    expose_len_d = expose_cycles;
                    cnt_d        = '0;
                    state_d      = S_ERASE;
                end
            end
            S_ERASE: begin
                if (erase_last) begin
                    cnt_d   = '0;
                    state_d = S_EXPOSE;
                end else begin
                    cnt_d = cnt_q + DUR_WIDTH'(1);
                end
            end
            S_EXPOSE: begin
                if (expose_last) begin
                    cnt_d   = '0;
                    state_d = S_CONVERT;
                end else begin
                    cnt_d = cnt_q + DUR_WIDTH'(1);
                end
            end
            S_CONVERT: begin
                // Ramp stops at all-ones; the counter drops back to 0 as we leave.
                if (ramp_last) begin
                    state_d = S_READ;
                end else begin
                    adc_d = adc_q + CNT_WIDTH'(1);
                end
            end
            S_READ: begin
                row_d = row_q;
                if (row_accept) begin
                    if (row_last) begin
                        row_d        = '0;
                        frame_done_d = 1'b1;
                        if (continuous) begin
                            erase_len_d  = erase_cycles;
                            expose_len_d = expose_cycles;
                            cnt_d        = '0;
                            state_d      = S_ERASE;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        erase_d     = (state_d == S_ERASE);
        expose_d    = (state_d == S_EXPOSE);
        convert_d   = (state_d == S_CONVERT);
        row_valid_d = (state_d == S_READ);
        busy_d      = (state_d != S_IDLE);
        for (int i = 0; i < N_ROWS; i++) begin
            read_row_d[i] = (state_d == S_READ) && (row_d == ROW_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            erase_len_q  <= '0;
            expose_len_q <= '0;
            adc_q        <= '0;
            row_q        <= '0;
            erase_q      <= 1'b0;
            expose_q     <= 1'b0;
            convert_q    <= 1'b0;
            read_row_q   <= '0;
            row_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            erase_len_q  <= erase_len_d;
            expose_len_q <= expose_len_d;
            adc_q        <= adc_d;
            row_q        <= row_d;
            erase_q      <= erase_d;
            expose_q     <= expose_d;
            convert_q    <= convert_d;
            read_row_q   <= read_row_d;
            row_valid_q  <= row_valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign erase       = erase_q;
    assign expose      = expose_q;
    assign convert     = convert_q;
    assign adc_counter = adc_q;
    assign read_row    = read_row_q;
    assign row_idx     = row_q;
    assign row_valid   = row_valid_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_pixel_sensor_ctrl.sv
// Directed bench for pixel_sensor_ctrl (N_ROWS=4, CNT_WIDTH=8, DUR_WIDTH=8).
// Inputs are driven and outputs sampled on the falling edge; t=0 is the sample after the start edge.
// Expected frame_done index = E + X + 256 + 4 (+ stalled cycles), with 0 durations counting as 1.
module tb_pixel_sensor_ctrl;
    localparam int N  = 4;
    localparam int CW = 8;
    localparam int DW = 8;
    localparam int RW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          continuous;
    logic [DW-1:0] erase_cycles;
    logic [DW-1:0] expose_cycles;
    logic          row_ready;
    logic          erase;
    logic          expose;
    logic          convert;
    logic [CW-1:0] adc_counter;
    logic [N-1:0]  read_row;
    logic [RW-1:0] row_idx;
    logic          row_valid;
    logic          busy;
    logic          frame_done;

    pixel_sensor_ctrl #(.N_ROWS(N), .CNT_WIDTH(CW), .DUR_WIDTH(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .continuous   (continuous),
        .erase_cycles (erase_cycles),
        .expose_cycles(expose_cycles),
        .row_ready    (row_ready),
        .erase        (erase),
        .expose       (expose),
        .convert      (convert),
        .adc_counter  (adc_counter),
        .read_row     (read_row),
        .row_idx      (row_idx),
        .row_valid    (row_valid),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Per-frame statistics gathered by run_frame.
    int n_er, n_ex, n_cv, fd_at, busy_low, excl_bad, adc_bad, oh_bad;
    int rc [N];
    int bp_left  = 0;   // cycles to stall row 1
    int start_at = -1;  // frame-relative cycle at which to pulse start
    int ecyc_at  = -1;  // frame-relative cycle at which to change erase_cycles
    logic [DW-1:0] ecyc_val;

    task automatic run_frame(input int limit);
        n_er = 0; n_ex = 0; n_cv = 0; fd_at = -1;
        busy_low = 0; excl_bad = 0; adc_bad = 0; oh_bad = 0;
        for (int r = 0; r < N; r++) rc[r] = 0;
        for (int t = 0; t < limit; t++) begin
            if (t > 0 && frame_done) begin
                fd_at = t;
                break;
            end
            if (int'(erase) + int'(expose) + int'(convert) + int'(row_valid) != 1) excl_bad++;
            if (erase)  n_er++;
            if (expose) n_ex++;
            if (convert) begin
                if (adc_counter != n_cv[CW-1:0]) adc_bad++;
                n_cv++;
            end else if (adc_counter != '0) begin
                adc_bad++;
            end
            if (!busy) busy_low++;
            if (row_valid) begin
                rc[row_idx]++;
                if (read_row != (4'b0001 << row_idx)) oh_bad++;
            end else if (read_row != '0 || row_idx != '0) begin
                oh_bad++;
            end
            row_ready = !(row_valid && row_idx == 2'd1 && bp_left > 0);
            if (!row_ready) bp_left--;
            start = (t == start_at);
            if (t == ecyc_at) erase_cycles = ecyc_val;
            @(negedge clk);
        end
        start     = 1'b0;
        row_ready = 1'b1;
    endtask

    task automatic kick(input logic [DW-1:0] e, input logic [DW-1:0] x);
        erase_cycles  = e;
        expose_cycles = x;
        start         = 1'b1;
        @(negedge clk);
        start         = 1'b0;
    endtask

    function automatic logic [19:0] all_outs();
        return {erase, expose, convert, adc_counter, read_row, row_idx, row_valid, busy, frame_done};
    endfunction

    int found;
    int extra_fd;

    initial begin
        reset = 1'b0; start = 1'b0; continuous = 1'b0;
        erase_cycles = '0; expose_cycles = '0; row_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("reset_outputs", all_outs(), 20'd0);
        reset = 1'b1;
        @(negedge clk);
        check_eq("idle_busy", busy, 0);

        // Single frame E=5 X=255
        kick(8'd5, 8'd255);
        run_frame(2000);
        check_eq("f1_erase_len", n_er, 5);
        check_eq("f1_expose_len", n_ex, 255);
        check_eq("f1_convert_len", n_cv, 256);
        check_eq("f1_adc_ramp", adc_bad, 0);
        check_eq("f1_exclusive", excl_bad, 0);
        check_eq("f1_onehot", oh_bad, 0);
        check_eq("f1_rows", {rc[0][7:0], rc[1][7:0], rc[2][7:0], rc[3][7:0]}, 32'h01010101);
        check_eq("f1_done_at", fd_at, 520);
        check_eq("f1_busy_at_done", busy, 0);
        check_eq("f1_busy_in_frame", busy_low, 0);
        @(negedge clk);
        check_eq("f1_done_pulse", frame_done, 0);
        check_eq("f1_idle_after", all_outs(), 20'd0);

        // Backpressure: row 1 stalled for 3 cycles
        bp_left = 3;
        kick(8'd1, 8'd1);
        run_frame(2000);
        check_eq("bp_row1_cycles", rc[1], 4);
        check_eq("bp_row0_cycles", rc[0], 1);
        check_eq("bp_row3_cycles", rc[3], 1);
        check_eq("bp_onehot", oh_bad, 0);
        check_eq("bp_done_at", fd_at, 265);
        @(negedge clk);

        // Zero durations behave as one cycle
        kick(8'd0, 8'd0);
        run_frame(2000);
        check_eq("zero_erase_len", n_er, 1);
        check_eq("zero_expose_len", n_ex, 1);
        check_eq("zero_done_at", fd_at, 262);
        @(negedge clk);

        // Continuous: mid-frame erase_cycles change applies to frame 2 only
        continuous = 1'b1;
        ecyc_at = 10; ecyc_val = 8'd2;
        kick(8'd3, 8'd4);
        run_frame(2000);
        ecyc_at = -1;
        check_eq("c1_erase_len", n_er, 3);
        check_eq("c1_done_at", fd_at, 267);
        check_eq("c1_erase_at_done", erase, 1);
        check_eq("c1_busy_at_done", busy, 1);
        check_eq("c1_busy_in_frame", busy_low, 0);
        continuous = 1'b0;
        run_frame(2000);
        check_eq("c2_erase_len", n_er, 2);
        check_eq("c2_expose_len", n_ex, 4);
        check_eq("c2_busy_in_frame", busy_low, 0);
        check_eq("c2_done_at", fd_at, 266);
        check_eq("c2_busy_at_done", busy, 0);
        @(negedge clk);

        // Reset in the middle of the convert ramp
        kick(8'd1, 8'd1);
        found = 0;
        for (int t = 0; t < 600; t++) begin
            if (convert && adc_counter == 8'd100) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check_eq("rst_reached_adc100", found, 1);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_mid_convert", all_outs(), 20'd0);
        reset = 1'b1;
        @(negedge clk);
        check_eq("rst_stays_idle", all_outs(), 20'd0);
        kick(8'd2, 8'd2);
        run_frame(2000);
        check_eq("rst_clean_convert", n_cv, 256);
        check_eq("rst_clean_adc", adc_bad, 0);
        check_eq("rst_clean_done_at", fd_at, 264);
        @(negedge clk);

        // start pulsed during expose is ignored
        start_at = 5;
        kick(8'd2, 8'd10);
        run_frame(2000);
        start_at = -1;
        check_eq("ign_erase_len", n_er, 2);
        check_eq("ign_done_at", fd_at, 272);
        extra_fd = 0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (frame_done || busy) extra_fd++;
        end
        check_eq("ign_no_second_frame", extra_fd, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
